// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator with one shared period counter.
//
// A single counter (edge- or center-aligned) feeds CHANNELS duty comparators.
// Period, mode and duty are double-buffered: a load strobe captures them into
// a pending buffer, and they move to the active set only at a period boundary.
// With WIDTH=8, period=255 and edge mode it reproduces the legacy 8-bit PWM.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   clken        tick enable; counter and outputs advance only when high
//   load         one-cycle strobe capturing period/mode/duty into pending
//   mode         0 = edge-aligned, 1 = center-aligned
//   period       top count P
//   duty         channel c duty at bits [c*WIDTH +: WIDTH]
//   out          registered PWM outputs
//   cycle_start  one-cycle pulse after each boundary tick
//   pending      captured values waiting for the next boundary
module pwm_multi #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clken,
    input  logic                      load,
    input  logic                      mode,
    input  logic [WIDTH-1:0]          period,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    output logic [CHANNELS-1:0]       out,
    output logic                      cycle_start,
    output logic                      pending
);

    typedef enum logic { DIR_UP = 1'b0, DIR_DOWN = 1'b1 } dir_t;
    typedef enum logic { MODE_EDGE = 1'b0, MODE_CENTER = 1'b1 } mode_t;

    logic [WIDTH-1:0]          cnt;
    dir_t                      dir;
    logic [WIDTH-1:0]          active_period;
    mode_t                     active_mode;
    logic [CHANNELS*WIDTH-1:0] active_duty;
    logic [WIDTH-1:0]          pend_period;
    mode_t                     pend_mode;
    logic [CHANNELS*WIDTH-1:0] pend_duty;

    logic [WIDTH-1:0]          cnt_next;
    dir_t                      dir_next;
    logic                      boundary;
    logic [WIDTH-1:0]          new_period;
    mode_t                     new_mode;
    logic [CHANNELS*WIDTH-1:0] new_duty;
    logic [CHANNELS-1:0]       out_next;

    // Comparator for one channel against the post-edge counter value.
    function automatic logic chan_out(input logic [WIDTH-1:0] d,
                                      input logic [WIDTH-1:0] p,
                                      input mode_t            m,
                                      input logic [WIDTH-1:0] c,
                                      input dir_t             dr);
        if (d == '0)
            return 1'b0;
        else if (d >= p)
            return 1'b1;
        else if (m == MODE_EDGE)
            return c < d;
        else if (dr == DIR_UP)
            return c < d;
        else
            return c <= d;
    endfunction

    always_comb begin
        cnt_next = '0;
        if (active_period == '0)
            cnt_next = '0;
        else if (active_mode == MODE_EDGE)
            cnt_next = (cnt >= active_period) ? '0 : cnt + 1'b1;
        else if (dir == DIR_UP)
            cnt_next = (cnt >= active_period) ? active_period - 1'b1 : cnt + 1'b1;
        else
            cnt_next = (cnt <= WIDTH'(1)) ? '0 : cnt - 1'b1;

        boundary = clken && (cnt_next == '0);

        // Direction is that of the phase the new count belongs to: returning
        // to 0 starts the up phase, reaching the top starts the down phase.
        if (cnt_next == '0)
            dir_next = DIR_UP;
        else if (cnt_next >= active_period)
            dir_next = DIR_DOWN;
        else
            dir_next = dir;

        // Values the outputs of this edge are computed with. On a boundary the
        // incoming set is used; cnt_next is 0 and dir_next is up there, so the
        // old period/mode used above for stepping cannot disagree with it.
        new_period = active_period;
        new_mode   = active_mode;
        new_duty   = active_duty;
        if (boundary) begin
            if (load) begin
                new_period = period;
                new_mode   = mode_t'(mode);
                new_duty   = duty;
            end else if (pending) begin
                new_period = pend_period;
                new_mode   = pend_mode;
                new_duty   = pend_duty;
            end
        end

        out_next = '0;
        for (int unsigned c = 0; c < CHANNELS; c++)
            out_next[c] = chan_out(new_duty[c*WIDTH +: WIDTH], new_period,
                                   new_mode, cnt_next, dir_next);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            dir           <= DIR_UP;
            out           <= '0;
            cycle_start   <= 1'b0;
            pending       <= 1'b0;
            active_period <= '1;
            active_mode   <= MODE_EDGE;
            active_duty   <= '0;
            pend_period   <= '1;
            pend_mode     <= MODE_EDGE;
            pend_duty     <= '0;
        end else begin
            cycle_start <= boundary;
            if (clken) begin
                cnt           <= cnt_next;
                dir           <= dir_next;
                out           <= out_next;
                active_period <= new_period;
                active_mode   <= new_mode;
                active_duty   <= new_duty;
            end
            if (boundary) begin
                pending <= 1'b0;
            end else if (load) begin
                pending     <= 1'b1;
                pend_period <= period;
                pend_mode   <= mode_t'(mode);
                pend_duty   <= duty;
            end
        end
    end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel, parametrised successor to the single 8-bit PWM generator. One shared period counter drives CHANNELS comparators, with a programmable period, edge- or center-aligned counting, and double-buffered (shadowed) duty/period/mode updates that take effect only at a period boundary. It sits beside the existing PWM users (LED dimming, motor/servo drive) and is enabled by the same clken tick strobe. With WIDTH=8, period=255 and mode=edge it matches the legacy 8-bit PWM duty behaviour.

## Interface

- WIDTH, 8, bit width of counter, period and each duty value
- CHANNELS, 4, number of PWM outputs

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- clken  in  1  tick enable; counter and outputs advance only when high
- load  in  1  one-cycle strobe: capture period, mode and duty into the pending buffer
- mode  in  1  0 = edge-aligned, 1 = center-aligned
- period  in  WIDTH  top count P
- duty  in  CHANNELS*WIDTH  channel c duty at bits [c*WIDTH +: WIDTH]
- out  out  CHANNELS  registered PWM outputs
- cycle_start  out  1  one-cycle pulse on the enabled tick where the counter returns to 0
- pending  out  1  high while captured values await transfer to active

## Operation

- Registers: cnt (WIDTH bits), dir (up/down, center mode only), and active_{period,mode,duty[c]}. The pending buffer holds the same fields plus a pending flag.
- Edge mode sequence: 0,1,…,P,0,… giving P+1 ticks per period.
- Center mode sequence: 0,1,…,P,P-1,…,1,0,… giving 2P ticks per period. dir flips to down after reaching P and to up after reaching 0.
- Channel rule for duty d, evaluated on the new cnt value:
  - d == 0: out low (highest priority).
  - d >= P: out high for the whole period.
  - Otherwise, edge mode: out = cnt < d, so d high ticks per period.
  - Otherwise, center mode: out = cnt < d in the up phase and cnt <= d in the down phase, so 2d high ticks forming one contiguous pulse centred on cnt = 0.
- P = 0: cnt stays 0 and every enabled tick is a boundary. out is high if d != 0, otherwise low.
- Boundary tick: an enabled tick whose next cnt is 0.
  - If pending is set, transfer pending to active on that edge and clear pending.
  - The out and cnt values computed on that same edge already use the new active values.
- load handling:
  - load is honoured regardless of clken. It overwrites pending values and sets pending.
  - A second load before transfer overwrites the first; the last load wins.
- load on a boundary tick: the values presented in that cycle are applied directly to active, and pending stays 0.
- A mode change mid-period never affects the current period.

## Timing

- Reset (rst high on an edge; overrides clken and load):
  - cnt = 0, dir = up, out = 0, cycle_start = 0, pending = 0.
  - active_period = all ones, active_mode = edge, active_duty = 0.
- cnt, dir, out and cycle_start are flops that update together on an enabled edge. There is no combinational path from any input to out.
- clken low: cnt, dir, out and active values hold, and cycle_start = 0. Pending capture still works.
- cycle_start is high for exactly one clk cycle after each boundary edge. Under clken gating it stays high for only one clk, not until the next tick.
- load → pending rises on the next edge. pending falls on the edge of the boundary tick that performs the transfer.
- Reset mid-period: the next enabled edge after rst deasserts produces cnt = 1. The first boundary occurs after a full default-period sequence.

## Test plan

- Legacy edge mode, WIDTH=8, clken=1, load P=255, mode=0, duty0=42 → exactly 42 high ticks in each of two consecutive 256-tick windows aligned to cycle_start.
- Extremes: duty0=0 → out[0] low for 1024 ticks. Then duty0=255 (P=255) → out[0] high for all 1024 ticks after the transfer boundary, with no single-tick drop.
- Center mode, load P=100, mode=1, duty1=30 → 60 high ticks per 200-tick period, one contiguous pulse spanning the cnt = 0 boundary, and cycle_start every 200 ticks.
- Shadowing, edge P=255, duty2=50:
  - load duty2=200 at cnt=100 → pending = 1 and the current period still shows 50 high ticks.
  - At the next cycle_start, pending = 0 and the period shows 200 high ticks.
  - load exactly on a boundary tick → applied immediately.
- clken: drop clken for 10 cycles mid-period → cnt, out and dir frozen, cycle_start = 0. A load issued during the gap raises pending.
- Reset mid-operation: assert rst at cnt=77 with pending = 1 → all outputs 0, pending = 0, active_period = 255, and the next enabled tick gives cnt = 1.
